// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: freezes on data-memory wait,
// inserts load-use bubbles, flushes IF/ID on taken branches and counts stall cycles.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_mem_mem_read,
    input  logic             ex_mem_mem_write,
    input  logic             dmem_ack,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             branch_taken,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic             mem_err_sticky,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    localparam logic [15:0]      REQ_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_nxt;
    logic [15:0] req_cnt, req_cnt_nxt;
    logic        mem_op, hazard, freeze, lu_stall, err_cycle, req_raw, stall_evt;

    assign mem_op = ex_mem_mem_read | ex_mem_mem_write;
    assign hazard = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        req_cnt_nxt = req_cnt;
        req_raw     = 1'b0;
        freeze      = 1'b0;
        err_cycle   = 1'b0;
        case (state)
            RUN: begin
                req_raw = mem_op;
                if (mem_op && !dmem_ack) begin
                    freeze      = 1'b1;
                    state_nxt   = WAIT;
                    req_cnt_nxt = 16'd1;
                end
            end
            WAIT: begin
                req_raw = 1'b1;
                if (dmem_ack) begin
                    // An ack on the final request cycle beats the timeout.
                    state_nxt   = RUN;
                    req_cnt_nxt = 16'd0;
                end else begin
                    freeze = mem_op;
                    if (req_cnt == REQ_LAST) begin
                        state_nxt = ERR;
                    end else begin
                        req_cnt_nxt = req_cnt + 16'd1;
                    end
                end
            end
            ERR: begin
                err_cycle   = 1'b1;
                state_nxt   = RUN;
                req_cnt_nxt = 16'd0;
            end
            default: begin
                state_nxt   = RUN;
                req_cnt_nxt = 16'd0;
            end
        endcase
    end

    assign lu_stall  = hazard && !freeze;
    assign stall_evt = rst && (freeze || lu_stall);

    // Outputs are held at their idle values while reset is low, regardless of inputs.
    always_comb begin
        dmem_req      = 1'b0;
        mem_err       = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst) begin
            dmem_req = req_raw;
            mem_err  = err_cycle;
            if (freeze) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
            end else begin
                // An abandoned access retires as a bubble so its load result is dropped.
                mem_wb_bubble = err_cycle;
                if (lu_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            req_cnt        <= 16'd0;
            mem_err_sticky <= 1'b0;
            stall_cnt      <= '0;
        end else begin
            state   <= state_nxt;
            req_cnt <= req_cnt_nxt;
            if (err_cycle) begin
                mem_err_sticky <= 1'b1;
            end
            if (stall_evt && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Generates the write enables and flushes for PC, IF/ID, ID/EX and EX/MEM. Arbitrates three stall sources: the variable-latency data-memory handshake for the instruction in EX/MEM, load-use hazards between ID/EX and IF/ID, and taken-branch flushes from ID. Also tracks memory timeouts and counts stall cycles.

## Interface
Parameters:
- TIMEOUT, 16, max consecutive request cycles without ack before a bus error (legal range 2..65535)
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- ex_mem_mem_read  in  1  EX/MEM stage holds a load
- ex_mem_mem_write  in  1  EX/MEM stage holds a store
- dmem_ack  in  1  data memory completes the current access this cycle
- id_ex_mem_read  in  1  ID/EX stage holds a load
- id_ex_rt  in  5  load destination register in ID/EX
- if_id_rs, if_id_rt  in  5 each  source registers of the instruction in IF/ID
- branch_taken  in  1  ID resolved a taken branch or jump
- dmem_req  out  1  data memory request
- pc_write  out  1  PC enable
- if_id_write  out  1  IF/ID enable
- id_ex_write  out  1  ID/EX enable
- ex_mem_write  out  1  EX/MEM enable
- if_id_flush  out  1  zero IF/ID on next edge
- id_ex_flush  out  1  load bubble into ID/EX control fields
- mem_wb_bubble  out  1  MEM/WB must capture a bubble (reg_write = 0)
- mem_err  out  1  one-cycle pulse: access abandoned on timeout
- mem_err_sticky  out  1  set on the first mem_err; cleared only by reset
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- mem_op = ex_mem_mem_read | ex_mem_mem_write.
- FSM states: RUN, WAIT, ERR.
- RUN:
  - dmem_req = mem_op.
  - mem_op & dmem_ack: zero-wait access; stay in RUN.
  - mem_op & !dmem_ack: freeze; go to WAIT; req_cnt <= 1.
- WAIT:
  - dmem_req = 1.
  - dmem_ack: release this cycle; go to RUN.
  - !dmem_ack & req_cnt == TIMEOUT-1: go to ERR.
  - Otherwise: req_cnt <= req_cnt + 1 and keep freezing.
- ERR:
  - dmem_req = 0; no freeze; mem_err = 1; mem_err_sticky <= 1; go to RUN.
  - The instruction retires with mem_wb_bubble = 1 (its load result is discarded).
- Freeze (RUN or WAIT with mem_op & !dmem_ack):
  - pc_write, if_id_write, id_ex_write and ex_mem_write are all 0.
  - mem_wb_bubble = 1; all flushes are 0.
  - Freeze has highest priority.
- Load-use stall (no freeze, and id_ex_mem_read & id_ex_rt != 0 & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt)):
  - pc_write = 0, if_id_write = 0, id_ex_flush = 1.
  - ID/EX and EX/MEM still advance.
  - branch_taken is ignored this cycle; ID re-evaluates it next cycle.
- Branch flush (no freeze, no load-use stall, branch_taken): if_id_flush = 1.
- Default: all enables 1, all flushes and mem_wb_bubble 0.
- Stall counting: stall_cnt increments on every freeze or load-use cycle and saturates at 2^CNT_W - 1.

## Timing
- Only state, req_cnt, mem_err_sticky and stall_cnt are registered. All other outputs are combinational from state and inputs in the same cycle.
- While rst = 0:
  - state = RUN, req_cnt = 0, stall_cnt = 0, mem_err_sticky = 0.
  - Outputs forced: dmem_req = 0, mem_err = 0, enables = 1, flushes = 0, mem_wb_bubble = 0.
- Reset asserted mid-WAIT aborts the access immediately. After release, the FSM resumes in RUN.
- Memory latency: access acked in cycle k after first request (k = 0 is the RUN cycle) stalls exactly k cycles. An ack in cycle 0 costs no stall.
- Timeout: TIMEOUT request cycles with no ack, then exactly one ERR cycle.
- dmem_ack outside a request is ignored.
- An ack in the same cycle as the timeout compare wins: go to RUN, no error.
- A load-use stall always lasts exactly one cycle, unless freeze overlaps. In that case the hazard is re-evaluated after the freeze ends.

## Test plan
- Load, ack in cycle 0: dmem_req = 1 for one cycle; no enable drops; stall_cnt stays 0.
- Store, ack in cycle 3: enables 0 and mem_wb_bubble 1 for cycles 0-2; release in cycle 3; stall_cnt = 3; state returns to RUN.
- TIMEOUT = 4, no ack: dmem_req high for 4 cycles; ERR on cycle 4 with mem_err = 1, dmem_req = 0, enables 1; mem_err_sticky = 1 afterwards.
- id_ex_mem_read = 1, id_ex_rt = 8, if_id_rs = 8, plus branch_taken = 1: pc_write = 0, if_id_write = 0, id_ex_flush = 1, if_id_flush = 0. With id_ex_rt = 0 there is no stall.
- Freeze concurrent with a load-use hazard and branch_taken: only the freeze outputs appear; the load-use stall follows on the first unfrozen cycle.
- rst pulled low during WAIT cycle 2: outputs revert immediately; after release dmem_req = mem_op and stall_cnt = 0. Also saturation: with CNT_W = 4 and 20 stall cycles, stall_cnt = 15.
